// File: rtl/gate_if.sv
// gate_if: operand/result bundle between the self-test controller and the gate block
interface gate_if;
  logic a_o, b_o;
  logic and_i, or_i, not_a_i, xor_i, xnor_i, nand_i;
  modport master(output a_o, b_o, input and_i, or_i, not_a_i, xor_i, xnor_i, nand_i);
  modport slave(input a_o, b_o, output and_i, or_i, not_a_i, xor_i, xnor_i, nand_i);
endinterface

// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: sweeps a gate block through all operand pairs and checks its six outputs
module gate_selftest_ctrl #(
  parameter int SWEEPS = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  gate_if.master           g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [5:0]       fail_mask,
  output logic [1:0]       first_fail,
  output logic             first_fail_vld
);
  localparam int SW_W = SWEEPS > 1 ? $clog2(SWEEPS) : 1;
  localparam int ST_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, ff_q, ff_d;
  logic [SW_W-1:0] sweep_q, sweep_d;
  logic [ST_W-1:0] settle_q, settle_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffv_q, ffv_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [5:0] mask_q, mask_d, m;
  logic a, b, last;
  assign a = idx_q[1];
  assign b = idx_q[0];
  assign g.a_o = a;
  assign g.b_o = b;
  assign m = {g.nand_i, g.xnor_i, g.xor_i, g.not_a_i, g.or_i, g.and_i}
           ^ {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  assign err_inc = &err_q ? err_q : err_q + 1'b1;
  assign last = idx_q == 2'd3 && sweep_q == SW_W'(SWEEPS - 1);
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_cnt = err_q;
  assign fail_mask = mask_q;
  assign first_fail = ff_q;
  assign first_fail_vld = ffv_q;
  // state and statistics registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      sweep_q <= '0;
      settle_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q <= '0;
      mask_q <= '0;
      ff_q <= '0;
      ffv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sweep_q <= sweep_d;
      settle_q <= settle_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q <= err_d;
      mask_q <= mask_d;
      ff_q <= ff_d;
      ffv_q <= ffv_d;
    end
  // sequencing: settle after each operand change, then judge the sampled outputs
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sweep_d = sweep_q;
    settle_d = settle_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d = err_q;
    mask_d = mask_q;
    ff_d = ff_q;
    ffv_d = ffv_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WAIT;
        idx_d = '0;
        sweep_d = '0;
        settle_d = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        pass_d = 1'b0;
        err_d = '0;
        mask_d = '0;
        ff_d = '0;
        ffv_d = 1'b0;
      end
      WAIT: begin
        settle_d = settle_q == ST_W'(SETTLE - 1) ? '0 : settle_q + 1'b1;
        state_d = settle_q == ST_W'(SETTLE - 1) ? CHECK : WAIT;
      end
      CHECK: begin
        mask_d = mask_q | m;
        err_d = |m ? err_inc : err_q;
        ff_d = (|m && !ffv_q) ? {a, b} : ff_q;
        ffv_d = ffv_q | (|m);
        if (last) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = err_d == '0;
        end else begin
          state_d = WAIT;
          idx_d = idx_q + 1'b1;
          sweep_d = idx_q == 2'd3 ? sweep_q + 1'b1 : sweep_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// tb_gate_selftest_ctrl: randomized fault-injection bench against a truth-table reference model
module tb_gate_selftest_ctrl;
  localparam int SW = 4;
  localparam int ST = 1;
  localparam int LAT = 4 * SW * (ST + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [5:0] flip [2][4];
  logic [1:0] busy_w, done_w, pass_w, ffv_w;
  logic [7:0] err0;
  logic [2:0] err1;
  logic [5:0] mask_w [2];
  logic [1:0] ff_w [2];
  logic [1:0] ab_w [2];
  int total = 0;
  int passed = 0;

  gate_if g0();
  gate_if g1();

  always #5 clk = ~clk;

  function automatic logic [5:0] gold(input logic a, input logic b);
    return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  assign {g0.nand_i, g0.xnor_i, g0.xor_i, g0.not_a_i, g0.or_i, g0.and_i} = gold(g0.a_o, g0.b_o) ^ flip[0][{g0.a_o, g0.b_o}];
  assign {g1.nand_i, g1.xnor_i, g1.xor_i, g1.not_a_i, g1.or_i, g1.and_i} = gold(g1.a_o, g1.b_o) ^ flip[1][{g1.a_o, g1.b_o}];
  assign ab_w[0] = {g0.a_o, g0.b_o};
  assign ab_w[1] = {g1.a_o, g1.b_o};

  gate_selftest_ctrl #(.SWEEPS(SW), .SETTLE(ST), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .g(g0.master),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err0),
    .fail_mask(mask_w[0]), .first_fail(ff_w[0]), .first_fail_vld(ffv_w[0]));

  gate_selftest_ctrl #(.SWEEPS(SW), .SETTLE(ST), .ERR_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .g(g1.master),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err1),
    .fail_mask(mask_w[1]), .first_fail(ff_w[1]), .first_fail_vld(ffv_w[1]));

  function automatic logic [7:0] errv(input int k);
    return k != 0 ? {5'b0, err1} : err0;
  endfunction

  function automatic logic [22:0] snap(input int k);
    return {ab_w[k], busy_w[k], done_w[k], pass_w[k], errv(k), mask_w[k], ff_w[k], ffv_w[k]};
  endfunction

  // reference: every sweep repeats the same per-pattern faults, so totals scale by SW
  task automatic model(input int k, output logic [7:0] err, output logic [5:0] mask,
                       output logic [1:0] ff, output logic ffv);
    int bad = 0;
    int emax = k != 0 ? 7 : 255;
    mask = '0;
    ff = '0;
    ffv = 1'b0;
    for (int p = 0; p < 4; p++)
      if (flip[k][p] != 6'd0) begin
        bad++;
        mask |= flip[k][p];
        if (!ffv) begin
          ff = 2'(p);
          ffv = 1'b1;
        end
      end
    err = 8'(SW * bad > emax ? emax : SW * bad);
  endtask

  task automatic run(input int k, input int extra_at, output int lat, output bit bok);
    @(posedge clk); #1 start_v[k] = 1'b1;
    @(posedge clk); #1 start_v[k] = 1'b0;
    lat = -1;
    bok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      start_v[k] = (n == extra_at);
      @(posedge clk); #1;
      if (done_w[k]) begin
        lat = n;
        if (busy_w[k]) bok = 1'b0;
        break;
      end
      if (!busy_w[k]) bok = 1'b0;
    end
    start_v[k] = 1'b0;
  endtask

  task automatic set_flips(input int k, input logic [5:0] f0, input logic [5:0] f1,
                           input logic [5:0] f2, input logic [5:0] f3);
    flip[k][0] = f0;
    flip[k][1] = f1;
    flip[k][2] = f2;
    flip[k][3] = f3;
  endtask

  task automatic test_case(input int k, input string name, input int extra_at);
    int lat;
    bit bok;
    logic [7:0] e;
    logic [5:0] m;
    logic [1:0] f;
    logic v;
    logic [18:0] got, exp;
    run(k, extra_at, lat, bok);
    model(k, e, m, f, v);
    total++;
    if (lat !== LAT || !bok) $display("FAIL %s latency: got %0d busy_ok=%0b, want %0d busy_ok=1", name, lat, bok, LAT);
    else passed++;
    got = {done_w[k], pass_w[k], errv(k), mask_w[k], ffv_w[k], ff_w[k]};
    exp = {1'b1, e == 8'd0, e, m, v, f};
    total++;
    if (got !== exp) $display("FAIL %s stats {done,pass,err,mask,ffv,ff}: got %h, want %h", name, got, exp);
    else passed++;
    total++;
    if (ab_w[k] !== 2'b11) $display("FAIL %s operands: got %b, want 11", name, ab_w[k]);
    else passed++;
  endtask

  task automatic test_reset;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (snap(k) !== '0) $display("FAIL reset_state[%0d]: got %h, want 0", k, snap(k));
      else passed++;
    end
    #6 rst = 1'b0;
  endtask

  task automatic test_random(input int iters);
    for (int i = 0; i < iters; i++) begin
      int k = i % 2;
      for (int p = 0; p < 4; p++)
        flip[k][p] = $urandom_range(0, 1) != 0 ? 6'($urandom_range(1, 63)) : 6'd0;
      test_case(k, $sformatf("random_%0d", i), 0);
    end
  endtask

  task automatic test_reset_midrun;
    set_flips(0, 6'h08, 6'h08, 6'h08, 6'h08);
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (snap(0) !== '0) $display("FAIL midrun_reset: got %h, want 0", snap(0));
    else passed++;
    #2 rst = 1'b0;
    set_flips(0, 6'h00, 6'h00, 6'h00, 6'h00);
    test_case(0, "post_reset", 0);
  endtask

  initial begin
    set_flips(0, 6'h00, 6'h00, 6'h00, 6'h00);
    set_flips(1, 6'h00, 6'h00, 6'h00, 6'h00);
    test_reset();
    test_case(0, "healthy", 0);
    set_flips(0, 6'h00, 6'h00, 6'h00, 6'h01);
    test_case(0, "and_stuck0", 0);
    set_flips(0, 6'h08, 6'h08, 6'h08, 6'h08);
    test_case(0, "xor_inverted", 0);
    set_flips(0, 6'h00, 6'h00, 6'h00, 6'h00);
    test_case(0, "restart_from_done", 0);
    test_case(0, "start_while_busy", 10);
    set_flips(1, 6'h3f, 6'h3f, 6'h3f, 6'h3f);
    test_case(1, "saturate", 0);
    test_random(8);
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
